// File: rtl/block_to_row_major_unpacker.sv
// block_to_row_major_unpacker
//
// Copies a K x N matrix stored in 4x4-block-tiled order out of a source SRAM
// into a destination SRAM in plain row-major order, one element per cycle.
// The source is read strictly sequentially; the destination address is built
// incrementally from nested counters (c, r, nb, kb, innermost first), so the
// per-element loop needs no multiplier.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high; aborts any transfer
//   start_i      start request, honoured only while idle
//   K_i, N_i     row / column count, latched with an accepted start
//   src_addr_o   tiled-source read address (holds its value outside READ)
//   src_rdata_i  source read data, one cycle after src_addr_o
//   dst_addr_o   row-major destination write address
//   dst_wdata_o  destination write data (source data passed straight through)
//   dst_we_o     destination write enable
//   busy_o       high whenever a transfer is in progress
//   done_o       one-cycle pulse after the last write
//   err_o        one-cycle pulse when a start request is rejected
module block_to_row_major_unpacker #(
  parameter int DataWidth     = 8,
  parameter int DataDepth     = 4096,
  parameter int AddrWidth     = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter int SizeAddrWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] K_i,
  input  logic [SizeAddrWidth-1:0] N_i,
  output logic [AddrWidth-1:0]     src_addr_o,
  input  logic [DataWidth-1:0]     src_rdata_i,
  output logic [AddrWidth-1:0]     dst_addr_o,
  output logic [DataWidth-1:0]     dst_wdata_o,
  output logic                     dst_we_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int BW = SizeAddrWidth - 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [BW-1:0]            kblk_q;
  logic [SizeAddrWidth-1:0] n_q;
  logic [AddrWidth-1:0]     s_q;
  logic [1:0]               c_q;
  logic [1:0]               r_q;
  logic [BW-1:0]            nb_q;
  logic [BW-1:0]            kb_q;
  logic [AddrWidth-1:0]     kb_base_q;
  logic [AddrWidth-1:0]     row_off_q;
  logic [AddrWidth-1:0]     col_q;
  logic [AddrWidth-1:0]     dst_addr_p1;
  logic                     vld_p1;
  logic                     err_q;

  logic [2*SizeAddrWidth-1:0] kn_prod;
  logic [63:0]                kn_wide;
  logic                       size_ok;
  logic                       accept;
  logic [AddrWidth-1:0]       n_a;
  logic [AddrWidth-1:0]       n4_a;
  logic [AddrWidth-1:0]       d_addr;
  logic                       nb_last;
  logic                       kb_last;
  logic                       last_elem;

  // Size check on the live inputs, done once per start at full product width.
  assign kn_prod = (2*SizeAddrWidth)'(K_i) * (2*SizeAddrWidth)'(N_i);
  assign kn_wide = 64'(kn_prod);
  assign size_ok = (K_i != '0) && (N_i != '0) &&
                   (K_i[1:0] == 2'b00) && (N_i[1:0] == 2'b00) &&
                   (kn_wide <= 64'(DataDepth));
  assign accept  = (state_q == IDLE) && start_i && size_ok;

  // Row term is tracked as kb_base (4*kb*N) plus row_off (r*N); col is 4*nb+c.
  assign n_a       = AddrWidth'(n_q);
  assign n4_a      = n_a << 2;
  assign d_addr    = kb_base_q + row_off_q + col_q;
  assign nb_last   = (nb_q == n_q[SizeAddrWidth-1:2] - BW'(1));
  assign kb_last   = (kb_q == kblk_q - BW'(1));
  assign last_elem = (c_q == 2'd3) && (r_q == 2'd3) && nb_last && kb_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    if (last_elem) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kblk_q      <= '0;
      n_q         <= '0;
      s_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      nb_q        <= '0;
      kb_q        <= '0;
      kb_base_q   <= '0;
      row_off_q   <= '0;
      col_q       <= '0;
      dst_addr_p1 <= '0;
      vld_p1      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && start_i && !size_ok;

      // p0 -> p1: the address issued now has its data back next cycle,
      // so the write address and write strobe are delayed by one stage.
      vld_p1 <= (state_q == READ);
      if (state_q == READ) dst_addr_p1 <= d_addr;

      if (accept) begin
        kblk_q    <= K_i[SizeAddrWidth-1:2];
        n_q       <= N_i;
        s_q       <= '0;
        c_q       <= '0;
        r_q       <= '0;
        nb_q      <= '0;
        kb_q      <= '0;
        kb_base_q <= '0;
        row_off_q <= '0;
        col_q     <= '0;
      end else if ((state_q == READ) && !last_elem) begin
        s_q <= s_q + AddrWidth'(1);
        c_q <= c_q + 2'd1;
        if (c_q != 2'd3) begin
          col_q <= col_q + AddrWidth'(1);
        end else if (r_q != 2'd3) begin
          // next row inside the same block: back to the block's first column
          r_q       <= r_q + 2'd1;
          row_off_q <= row_off_q + n_a;
          col_q     <= col_q - AddrWidth'(3);
        end else begin
          r_q       <= 2'd0;
          row_off_q <= '0;
          if (!nb_last) begin
            nb_q  <= nb_q + BW'(1);
            col_q <= col_q + AddrWidth'(1);
          end else begin
            nb_q      <= '0;
            col_q     <= '0;
            kb_q      <= kb_q + BW'(1);
            kb_base_q <= kb_base_q + n4_a;
          end
        end
      end
    end
  end

  assign src_addr_o  = s_q;
  assign dst_addr_o  = dst_addr_p1;
  assign dst_we_o    = vld_p1;
  // Gated so the write-data bus reads zero whenever no write is in flight.
  assign dst_wdata_o = vld_p1 ? src_rdata_i : '0;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_block_to_row_major_unpacker.sv
module tb_block_to_row_major_unpacker;

  localparam int DW = 8;
  localparam int DD = 4096;
  localparam int AW = 12;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [SW-1:0] K_i;
  logic [SW-1:0] N_i;
  logic [AW-1:0] src_addr_o;
  logic [DW-1:0] src_rdata_i;
  logic [AW-1:0] dst_addr_o;
  logic [DW-1:0] dst_wdata_o;
  logic          dst_we_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  logic [DW-1:0] src_mem [DD];
  logic [DW-1:0] dst_mem [DD];

  int n_vec = 0;
  int n_err = 0;

  block_to_row_major_unpacker #(
    .DataWidth(DW), .DataDepth(DD), .AddrWidth(AW), .SizeAddrWidth(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .K_i(K_i), .N_i(N_i),
    .src_addr_o(src_addr_o), .src_rdata_i(src_rdata_i),
    .dst_addr_o(dst_addr_o), .dst_wdata_o(dst_wdata_o), .dst_we_o(dst_we_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Source SRAM with one-cycle read latency
  always @(posedge clk) src_rdata_i <= src_mem[src_addr_o];

  // Tiled source index holding matrix element (i, j)
  function automatic int ref_src(input int n, input int i, input int j);
    return ((i / 4) * (n / 4) + (j / 4)) * 16 + (i % 4) * 4 + (j % 4);
  endfunction

  task automatic fill_src(input bit ramp);
    for (int i = 0; i < DD; i++) src_mem[i] = ramp ? DW'(i) : DW'($urandom);
  endtask

  // Runs one transfer starting at the current negedge. abort_after >= 0 asserts
  // reset once that many writes have been seen; mid_start pulses start mid-run.
  task automatic run_xfer(input int k, input int n, input int abort_after,
                          input bit mid_start);
    int kn, wcnt, bcnt;
    bit aborted;
    logic [3:0] got, exp;
    kn = k * n;
    wcnt = 0;
    bcnt = 0;
    aborted = 0;
    for (int i = 0; i < DD; i++) dst_mem[i] = 'x;
    K_i = SW'(k);
    N_i = SW'(n);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 1; t <= kn + 3; t++) begin
      if (t > 1) @(negedge clk);
      if (mid_start && t == 10) begin start_i = 1'b1; K_i = 4; N_i = 4; end
      if (mid_start && t == 11) start_i = 1'b0;
      exp = {1'(t >= 2 && t <= kn + 1), 1'(t == kn + 2), 1'(t <= kn + 2), 1'b0};
      got = {dst_we_o, done_o, busy_o, err_o};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ctl K=%0d N=%0d cycle %0d: we/done/busy/err=%b expected %b",
                 k, n, t, got, exp);
      end
      if (busy_o === 1'b1) bcnt++;
      if (dst_we_o === 1'b1) begin
        dst_mem[dst_addr_o] = dst_wdata_o;
        wcnt++;
      end
      if (abort_after >= 0 && wcnt == abort_after) begin
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      rst_i = 1'b1;
      #1;
      n_vec++;
      if ({busy_o, done_o, err_o, dst_we_o} !== 4'b0000) begin
        n_err++;
        $display("FAIL abort_ctl: busy/done/err/we=%b expected 0000",
                 {busy_o, done_o, err_o, dst_we_o});
      end
      n_vec++;
      if (src_addr_o !== '0 || dst_addr_o !== '0) begin
        n_err++;
        $display("FAIL abort_addr: src=%0d dst=%0d expected 0 0", src_addr_o, dst_addr_o);
      end
      n_vec++;
      if (dst_wdata_o !== '0) begin
        n_err++;
        $display("FAIL abort_wdata: got %0d expected 0", dst_wdata_o);
      end
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({busy_o, dst_we_o, done_o} !== 3'b000) begin
        n_err++;
        $display("FAIL after_abort: busy/we/done=%b expected 000", {busy_o, dst_we_o, done_o});
      end
    end else begin
      n_vec++;
      if (wcnt != kn) begin
        n_err++;
        $display("FAIL write_count K=%0d N=%0d: got %0d expected %0d", k, n, wcnt, kn);
      end
      n_vec++;
      if (bcnt != kn + 2) begin
        n_err++;
        $display("FAIL busy_cycles K=%0d N=%0d: got %0d expected %0d", k, n, bcnt, kn + 2);
      end
      for (int i = 0; i < k; i++) begin
        for (int j = 0; j < n; j++) begin
          n_vec++;
          if (dst_mem[i * n + j] !== src_mem[ref_src(n, i, j)]) begin
            n_err++;
            $display("FAIL dst K=%0d N=%0d [%0d]: got %h expected %h", k, n,
                     i * n + j, dst_mem[i * n + j], src_mem[ref_src(n, i, j)]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    K_i = '0;
    N_i = '0;
    for (int i = 0; i < DD; i++) src_mem[i] = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_o, done_o, err_o, dst_we_o, src_addr_o, dst_addr_o, dst_wdata_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy/done/err/we=%b src=%0d dst=%0d wdata=%0d expected all 0",
               {busy_o, done_o, err_o, dst_we_o}, src_addr_o, dst_addr_o, dst_wdata_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_ramp_12x8();
    logic [DW-1:0] exp_v [3];
    int idx [3];
    fill_src(1);
    run_xfer(12, 8, -1, 0);
    idx = '{4, 9, 95};
    exp_v = '{8'd16, 8'd5, 8'd95};
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (dst_mem[idx[i]] !== exp_v[i]) begin
        n_err++;
        $display("FAIL ramp_dst[%0d]: got %0d expected %0d", idx[i], dst_mem[idx[i]], exp_v[i]);
      end
    end
  endtask

  task automatic test_single_block();
    fill_src(0);
    run_xfer(4, 4, -1, 0);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (dst_mem[i] !== src_mem[i]) begin
        n_err++;
        $display("FAIL identity[%0d]: got %h expected %h", i, dst_mem[i], src_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_src(0);
    run_xfer(8, 12, -1, 1);
    fill_src(0);
    run_xfer(8, 12, -1, 0);
  endtask

  task automatic test_errors();
    int ks [3];
    int ns [3];
    ks = '{6, 0, 128};
    ns = '{8, 8, 128};
    for (int c = 0; c < 3; c++) begin
      K_i = SW'(ks[c]);
      N_i = SW'(ns[c]);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n_vec++;
      if ({err_o, busy_o, dst_we_o} !== 3'b100) begin
        n_err++;
        $display("FAIL reject K=%0d N=%0d: err/busy/we=%b expected 100",
                 ks[c], ns[c], {err_o, busy_o, dst_we_o});
      end
      @(negedge clk);
      n_vec++;
      if ({err_o, busy_o, dst_we_o} !== 3'b000) begin
        n_err++;
        $display("FAIL reject_after K=%0d N=%0d: err/busy/we=%b expected 000",
                 ks[c], ns[c], {err_o, busy_o, dst_we_o});
      end
    end
  endtask

  task automatic test_abort();
    fill_src(0);
    run_xfer(12, 8, 20, 0);
    fill_src(0);
    run_xfer(4, 8, -1, 0);
  endtask

  task automatic test_random();
    int k, n;
    for (int run = 0; run < 10; run++) begin
      do begin
        k = 4 * int'($urandom_range(1, 16));
        n = 4 * int'($urandom_range(1, 16));
      end while (k * n > DD);
      fill_src(0);
      run_xfer(k, n, -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_12x8();
    test_single_block();
    test_back_to_back();
    test_errors();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
